// File: rtl/imm_gen_fifo.sv
// Registered immediate generator: decodes 16-bit instructions at write time into a DEPTH-entry FIFO.
// Optional IMM_GEN_FIFO_STATS_EN adds pcrel_cnt, a saturating count of popped PC-relative entries.
module imm_gen_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_instr,
    output logic [DATA_W-1:0]        out_imm,
    output logic                     out_pcrel,
    output logic [$clog2(DEPTH):0]   count
`ifdef IMM_GEN_FIFO_STATS_EN
    ,
    output logic [15:0]              pcrel_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [15:0]       mem_instr [DEPTH];
    logic [DATA_W-1:0] mem_imm   [DEPTH];
    logic              mem_pcrel [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic          push;
    logic          pop;

    function automatic logic [DATA_W-1:0] decode(input logic [15:0] ins);
        logic [DATA_W-1:0] imm;
        imm = '0;
        case (ins[2:0])
            3'b001:        imm = {{(DATA_W-5){ins[13]}}, ins[13:9]};
            3'b010, 3'b011: imm = {{(DATA_W-7){ins[15]}}, ins[15:9]};
            3'b100, 3'b101: imm = {{(DATA_W-8){ins[15]}}, ins[15:12], ins[5:3], 1'b0};
            3'b110, 3'b111: imm = {{(DATA_W-11){ins[15]}}, ins[15:6], 1'b0};
            default:       imm = '0;
        endcase
        return imm;
    endfunction

    // Ready depends only on occupancy, so a full FIFO refuses a push even when popping.
    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_instr = mem_instr[rd_ptr];
    assign out_imm   = mem_imm[rd_ptr];
    assign out_pcrel = mem_pcrel[rd_ptr];
    assign count     = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
        end
    end

    // Storage carries no reset; contents are meaningless while out_valid is low.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_instr[wr_ptr] <= in_instr;
            mem_imm[wr_ptr]   <= decode(in_instr);
            mem_pcrel[wr_ptr] <= in_instr[2];
        end
    end

`ifdef IMM_GEN_FIFO_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            pcrel_cnt <= '0;
        end else if (pop && out_pcrel && (pcrel_cnt != 16'hFFFF)) begin
            pcrel_cnt <= pcrel_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imm_gen_fifo.sv
// Scoreboard bench for imm_gen_fifo: a queue-based reference model predicts every output,
// directed test-plan checks plus a long randomized run with occasional resets.
module tb_imm_gen_fifo;

    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   in_instr;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_instr;
    logic [DW-1:0] out_imm;
    logic          out_pcrel;
    logic [2:0]    count;
`ifdef IMM_GEN_FIFO_STATS_EN
    logic [15:0]   pcrel_cnt;
`endif

    imm_gen_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_imm   (out_imm),
        .out_pcrel (out_pcrel),
        .count     (count)
`ifdef IMM_GEN_FIFO_STATS_EN
        ,
        .pcrel_cnt (pcrel_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]   instr;
        logic [DW-1:0] imm;
        logic          pcrel;
    } entry_t;

    entry_t model_q[$];
    int     model_pcrel_cnt = 0;
    bit     last_accepted = 0;
    int     checks = 0;
    int     errors = 0;

    // Reference decode from the field rules using signed integer arithmetic.
    function automatic logic [DW-1:0] ref_imm(input logic [15:0] ins);
        int v;
        v = 0;
        case (ins[2:0])
            3'd1: begin v = int'(ins[13:9]); if (v >= 16) v -= 32; end
            3'd2, 3'd3: begin v = int'(ins[15:9]); if (v >= 64) v -= 128; end
            3'd4, 3'd5: begin
                v = int'(ins[15:12]) * 16 + int'(ins[5:3]) * 2;
                if (v >= 128) v -= 256;
            end
            3'd6, 3'd7: begin v = int'(ins[15:6]) * 2; if (v >= 1024) v -= 2048; end
            default: v = 0;
        endcase
        return DW'(v);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: advances on each rising edge from the pre-edge inputs.
    always @(posedge clk) begin
        bit do_push, do_pop;
        entry_t e;
        do_push = in_valid && (model_q.size() < DEPTH);
        do_pop  = out_ready && (model_q.size() > 0);
        if (reset) begin
            model_q.delete();
            model_pcrel_cnt = 0;
            last_accepted = 0;
        end else begin
            if (do_pop) begin
                if (model_q[0].pcrel && model_pcrel_cnt < 16'hFFFF) model_pcrel_cnt++;
                void'(model_q.pop_front());
            end
            if (do_push) begin
                e.instr = in_instr;
                e.imm   = ref_imm(in_instr);
                e.pcrel = in_instr[2];
                model_q.push_back(e);
            end
            last_accepted = do_push;
        end
    end

    // Monitor: compares DUT outputs to the model away from the active edge.
    always @(negedge clk) begin
        chk("count", longint'(count), longint'(model_q.size()));
        chk("out_valid", longint'(out_valid), longint'(model_q.size() != 0));
        chk("in_ready", longint'(in_ready), longint'(model_q.size() != DEPTH));
`ifdef IMM_GEN_FIFO_STATS_EN
        chk("pcrel_cnt", longint'(pcrel_cnt), longint'(model_pcrel_cnt));
`endif
        if (model_q.size() != 0 && out_valid) begin
            chk("out_instr", longint'(out_instr), longint'(model_q[0].instr));
            chk("out_imm", longint'(out_imm), longint'(model_q[0].imm));
            chk("out_pcrel", longint'(out_pcrel), longint'(model_q[0].pcrel));
        end
    end

    // One clock cycle; on return the DUT reflects this cycle's handshake.
    task automatic drive(input logic v, input logic [15:0] ins, input logic rdy);
        in_valid  = v;
        in_instr  = ins;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] ins;
        reset = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset_count", longint'(count), 0);
        chk("reset_in_ready", longint'(in_ready), 1);
        reset = 1'b0;

        drive(1, 16'h3E01, 0);
        chk("tp1_valid", longint'(out_valid), 1);
        chk("tp1_imm", longint'(out_imm), 64'hFFFF);
        chk("tp1_pcrel", longint'(out_pcrel), 0);
        chk("tp1_count", longint'(count), 1);
        drive(0, 16'h0000, 1);

        drive(1, 16'h7E02, 1);
        chk("tp2_imm0", longint'(out_imm), 64'h003F);
        chk("tp2_pcrel0", longint'(out_pcrel), 0);
        drive(1, 16'h1004, 1);
        chk("tp2_imm1", longint'(out_imm), 64'h0010);
        chk("tp2_pcrel1", longint'(out_pcrel), 1);
        drive(1, 16'hFFC6, 1);
        chk("tp2_imm2", longint'(out_imm), 64'hFFFE);
        chk("tp2_pcrel2", longint'(out_pcrel), 1);
        drive(0, 16'h0000, 1);
        chk("tp2_empty", longint'(out_valid), 0);

        for (int i = 0; i < 4; i++) drive(1, 16'(16'h1111 * (i + 1)), 0);
        chk("full_count", longint'(count), 4);
        chk("full_in_ready", longint'(in_ready), 0);
        drive(1, 16'hABCD, 0);
        chk("full_5th_rejected", longint'(count), 4);
        drive(0, 16'h0000, 1);
        chk("full_release_ready", longint'(in_ready), 1);
        chk("full_head_order", longint'(out_instr), 64'h2222);
        for (int i = 0; i < 3; i++) drive(0, 16'h0000, 1);

        drive(1, 16'(($urandom) & 16'hFFFF), 0);
        drive(1, 16'(($urandom) & 16'hFFFF), 0);
        for (int i = 0; i < 10; i++) begin
            drive(1, 16'($urandom_range(0, 65535)), 1);
            chk("wrap_count", longint'(count), 2);
        end
        drive(0, 16'h0000, 1);
        drive(0, 16'h0000, 1);

        for (int i = 0; i < 3; i++) drive(1, 16'h0E07 + 16'(i), 1'b0);
        chk("pre_reset_count", longint'(count), 3);
        reset = 1'b1;
        drive(1, 16'hFFFF, 1);
        reset = 1'b0;
        chk("rst_count", longint'(count), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_in_ready", longint'(in_ready), 1);
`ifdef IMM_GEN_FIFO_STATS_EN
        chk("rst_pcrel_cnt", longint'(pcrel_cnt), 0);
`endif

        // Randomized traffic; a refused instruction is held until accepted.
        ins = 16'($urandom_range(0, 65535));
        in_valid = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic v;
            if (in_valid && !last_accepted) begin
                v = 1'b1;
            end else begin
                v = ($urandom_range(0, 99) < 60);
                ins = 16'($urandom_range(0, 65535));
            end
            reset = ($urandom_range(0, 299) == 0);
            drive(v, ins, ($urandom_range(0, 99) < 50));
            if (reset) in_valid = 1'b0;
            reset = 1'b0;
        end
        in_valid = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) drive(0, 16'h0000, 1);
        chk("final_empty", longint'(count), 0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
